// File: rtl/cpu_dbg_pkg.sv
// Shared command/state types and the s2 register map used by the CPU debug master.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        OP_HALT     = 3'd0,
        OP_RUN      = 3'd1,
        OP_STEP     = 3'd2,
        OP_SNAPSHOT = 3'd3,
        OP_READ     = 3'd4,
        OP_WRITE    = 3'd5
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RSP     = 3'd4
    } dbg_state_e;

    localparam logic [6:0] CSR_CYCLE_LO     = 7'h00;
    localparam logic [6:0] CSR_CYCLE_HI     = 7'h04;
    localparam logic [6:0] CSR_STEP_EN      = 7'h08;
    localparam logic [6:0] CSR_STEPS        = 7'h0C;
    localparam logic [6:0] CSR_INSTR_IF     = 7'h10;
    localparam logic [6:0] CSR_INSTR_DE     = 7'h14;
    localparam logic [6:0] CSR_INSTR_EX     = 7'h18;
    localparam logic [6:0] CSR_INSTR_MEM    = 7'h1C;
    localparam logic [6:0] CSR_INSTR_WB     = 7'h20;
    localparam logic [6:0] CSR_SCRATCH_BASE = 7'h40;

    localparam logic [2:0]  SNAP_LAST_IDX = 3'd6;
    localparam logic [31:0] ILLEGAL_TAG   = 32'hDEAD_0000;

    // Snapshot read order: cycle counter then the five pipeline-stage instruction words.
    function automatic logic [6:0] snap_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    snap_addr = CSR_CYCLE_LO;
            3'd1:    snap_addr = CSR_CYCLE_HI;
            3'd2:    snap_addr = CSR_INSTR_IF;
            3'd3:    snap_addr = CSR_INSTR_DE;
            3'd4:    snap_addr = CSR_INSTR_EX;
            3'd5:    snap_addr = CSR_INSTR_MEM;
            3'd6:    snap_addr = CSR_INSTR_WB;
            default: snap_addr = CSR_CYCLE_LO;
        endcase
    endfunction

endpackage

// File: rtl/cpu_debug_master.sv
// Debug-port initiator: turns host debug commands into s2 read/write sequences
// and streams read results back through a single registered response slot.
module cpu_debug_master
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter int unsigned ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic [31:0]       m_readdata,
    output logic              m_write,
    output logic [31:0]       m_writedata
);

    localparam logic [31:0]       POLL_LIMIT = 32'(POLL_TIMEOUT);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(2'd3);

    dbg_state_e        state_r, state_s;
    logic [2:0]        op_r, op_s;
    logic              second_wr_r, second_wr_s;
    logic [2:0]        snap_idx_r, snap_idx_s;
    logic [31:0]       poll_cnt_r, poll_cnt_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [31:0]       rsp_data_r, rsp_data_s;
    logic              rsp_last_r, rsp_last_s;
    logic              rsp_err_r, rsp_err_s;
    logic [ADDR_W-1:0] m_address_r, m_address_s;
    logic              m_read_r, m_read_s;
    logic              m_write_r, m_write_s;
    logic [31:0]       m_writedata_r, m_writedata_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        if (cnt >= POLL_LIMIT) begin
            sat_inc = POLL_LIMIT;
        end else begin
            sat_inc = cnt + 32'd1;
        end
    endfunction

    // Next-state and next-output decode; strobes default low so they are one-cycle pulses.
    always_comb begin
        state_s       = state_r;
        op_s          = op_r;
        second_wr_s   = second_wr_r;
        snap_idx_s    = snap_idx_r;
        poll_cnt_s    = poll_cnt_r;
        cmd_ready_s   = cmd_ready_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_data_s    = rsp_data_r;
        rsp_last_s    = rsp_last_r;
        rsp_err_s     = rsp_err_r;
        m_read_s      = 1'b0;
        m_write_s     = 1'b0;
        m_address_s   = '0;
        m_writedata_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    op_s        = cmd_op;
                    cmd_ready_s = 1'b0;
                    second_wr_s = 1'b0;
                    snap_idx_s  = 3'd0;
                    poll_cnt_s  = 32'd0;
                    case (cmd_op)
                        OP_HALT: begin
                            state_s     = ST_WR;
                            m_write_s   = 1'b1;
                            m_address_s = ADDR_W'(CSR_STEPS);
                            second_wr_s = 1'b1;
                        end
                        OP_RUN: begin
                            state_s     = ST_WR;
                            m_write_s   = 1'b1;
                            m_address_s = ADDR_W'(CSR_STEP_EN);
                        end
                        OP_STEP: begin
                            state_s       = ST_WR;
                            m_write_s     = 1'b1;
                            m_address_s   = ADDR_W'(CSR_STEPS);
                            m_writedata_s = cmd_data;
                            second_wr_s   = 1'b1;
                        end
                        OP_SNAPSHOT: begin
                            state_s     = ST_RD_REQ;
                            m_read_s    = 1'b1;
                            m_address_s = ADDR_W'(snap_addr(3'd0));
                        end
                        OP_READ: begin
                            state_s     = ST_RD_REQ;
                            m_read_s    = 1'b1;
                            m_address_s = cmd_addr & WORD_MASK;
                        end
                        OP_WRITE: begin
                            state_s       = ST_WR;
                            m_write_s     = 1'b1;
                            m_address_s   = cmd_addr & WORD_MASK;
                            m_writedata_s = cmd_data;
                        end
                        default: begin
                            state_s     = ST_RSP;
                            rsp_valid_s = 1'b1;
                            rsp_data_s  = ILLEGAL_TAG | {29'd0, cmd_op};
                            rsp_last_s  = 1'b1;
                            rsp_err_s   = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // HALT and STEP both arm the stepper by setting step_en last.
                if (second_wr_r) begin
                    second_wr_s   = 1'b0;
                    m_write_s     = 1'b1;
                    m_address_s   = ADDR_W'(CSR_STEP_EN);
                    m_writedata_s = 32'd1;
                end else if ((op_r == OP_STEP) && (POLL_LIMIT != 32'd0)) begin
                    state_s     = ST_RD_REQ;
                    m_read_s    = 1'b1;
                    m_address_s = ADDR_W'(CSR_STEPS);
                    poll_cnt_s  = sat_inc(poll_cnt_r);
                end else begin
                    state_s     = ST_IDLE;
                    cmd_ready_s = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (op_r == OP_STEP) begin
                    if (m_readdata == 32'd0) begin
                        state_s     = ST_RSP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = poll_cnt_r;
                        rsp_last_s  = 1'b1;
                        rsp_err_s   = 1'b0;
                    end else if (poll_cnt_r >= POLL_LIMIT) begin
                        state_s     = ST_RSP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = m_readdata;
                        rsp_last_s  = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else begin
                        state_s     = ST_RD_REQ;
                        m_read_s    = 1'b1;
                        m_address_s = ADDR_W'(CSR_STEPS);
                        poll_cnt_s  = sat_inc(poll_cnt_r);
                    end
                end else begin
                    state_s     = ST_RSP;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = m_readdata;
                    rsp_last_s  = (op_r == OP_READ) || (snap_idx_r == SNAP_LAST_IDX);
                    rsp_err_s   = 1'b0;
                end
            end
            ST_RSP: begin
                // The next snapshot read waits for the consumer, so only one word is ever buffered.
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    rsp_last_s  = 1'b0;
                    rsp_err_s   = 1'b0;
                    if (rsp_last_r) begin
                        state_s     = ST_IDLE;
                        cmd_ready_s = 1'b1;
                    end else begin
                        state_s     = ST_RD_REQ;
                        snap_idx_s  = snap_idx_r + 3'd1;
                        m_read_s    = 1'b1;
                        m_address_s = ADDR_W'(snap_addr(snap_idx_r + 3'd1));
                    end
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cmd_ready_s = 1'b1;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            op_r          <= 3'd0;
            second_wr_r   <= 1'b0;
            snap_idx_r    <= 3'd0;
            poll_cnt_r    <= 32'd0;
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_last_r    <= 1'b0;
            rsp_err_r     <= 1'b0;
            m_address_r   <= '0;
            m_read_r      <= 1'b0;
            m_write_r     <= 1'b0;
            m_writedata_r <= 32'd0;
        end else begin
            state_r       <= state_s;
            op_r          <= op_s;
            second_wr_r   <= second_wr_s;
            snap_idx_r    <= snap_idx_s;
            poll_cnt_r    <= poll_cnt_s;
            cmd_ready_r   <= cmd_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_last_r    <= rsp_last_s;
            rsp_err_r     <= rsp_err_s;
            m_address_r   <= m_address_s;
            m_read_r      <= m_read_s;
            m_write_r     <= m_write_s;
            m_writedata_r <= m_writedata_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_last    = rsp_last_r;
    assign rsp_err     = rsp_err_r;
    assign m_address   = m_address_r;
    assign m_read      = m_read_r;
    assign m_write     = m_write_r;
    assign m_writedata = m_writedata_r;

endmodule

// File: tb/tb_cpu_debug_master.sv
// Bench for cpu_debug_master: models the s2 slave (registered readdata, self-draining
// manual_steps) and checks each debug command against expected bus and response traffic.
module tb_cpu_debug_master;
    import cpu_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_data;
    logic [6:0]  m_address;
    logic        m_read, m_write;
    logic [31:0] m_readdata, m_writedata;

    always #5 clk = ~clk;

    cpu_debug_master #(.POLL_TIMEOUT(4096), .ADDR_W(7)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .m_write(m_write), .m_writedata(m_writedata)
    );

    // ---------------- s2 slave model ----------------
    localparam logic [63:0] S_CYCLE = 64'h1_0000_0002;
    localparam logic [31:0] S_INSTR [5] = '{32'h13, 32'h33, 32'h63, 32'h03, 32'h23};
    localparam logic [31:0] EXP_SNAP [7] = '{32'h2, 32'h1, 32'h13, 32'h33, 32'h63, 32'h03, 32'h23};
    localparam logic [6:0]  EXP_SNAP_A [7] = '{7'h00, 7'h04, 7'h10, 7'h14, 7'h18, 7'h1C, 7'h20};

    logic        freeze = 1'b0;
    logic [31:0] s_step_en, s_steps, s_rdata;
    logic [31:0] s_scratch [16];
    logic [6:0]  rd_log [$];
    logic [6:0]  wr_a_log [$];
    logic [31:0] wr_d_log [$];
    int          strobe_cnt = 0, both_cnt = 0, rsp_cnt = 0;

    assign m_readdata = s_rdata;

    function automatic logic [31:0] slave_rd(input logic [6:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a >= 7'h40) v = s_scratch[a[5:2]];
        else if (a[6:2] == 5'd0) v = S_CYCLE[31:0];
        else if (a[6:2] == 5'd1) v = S_CYCLE[63:32];
        else if (a[6:2] == 5'd2) v = s_step_en;
        else if (a[6:2] == 5'd3) v = s_steps;
        else if (a[6:2] >= 5'd4 && a[6:2] <= 5'd8) v = S_INSTR[a[6:2] - 5'd4];
        return v;
    endfunction

    always @(posedge clk) begin
        if (m_read || m_write) strobe_cnt <= strobe_cnt + 1;
        if (m_read && m_write) both_cnt <= both_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (m_read) rd_log.push_back(m_address);
        if (m_write) begin
            wr_a_log.push_back(m_address);
            wr_d_log.push_back(m_writedata);
        end
        if (reset) begin
            s_step_en <= 32'd0;
            s_steps   <= 32'd0;
            s_rdata   <= 32'd0;
            for (int i = 0; i < 16; i++) s_scratch[i] <= 32'd0;
        end else begin
            if (m_read) s_rdata <= slave_rd(m_address);
            if (m_write && m_address == 7'h08) s_step_en <= m_writedata;
            if (m_write && m_address >= 7'h40) s_scratch[m_address[5:2]] <= m_writedata;
            if (m_write && m_address == 7'h0C) s_steps <= m_writedata;
            else if (!freeze && s_steps != 32'd0) s_steps <= s_steps - 32'd1;
        end
    end

    // ---------------- checking helpers ----------------
    int          errors = 0, checks = 0;
    logic [31:0] got_d [$];
    logic        got_l [$];
    logic        got_e [$];
    logic [31:0] ref_scratch [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [6:0] a, input logic [31:0] d);
        wait_idle(tag);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 7'd0; cmd_data = 32'd0;
    endtask

    task automatic collect(input bit toggle);
        bit          done, have_hold;
        logic [31:0] hold;
        done = 1'b0; have_hold = 1'b0; hold = 32'd0;
        got_d.delete(); got_l.delete(); got_e.delete();
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            rsp_ready = toggle ? ~rsp_ready : 1'b1;
            if (rsp_valid) begin
                if (have_hold) check("rsp_hold", rsp_data, hold);
                if (rsp_ready) begin
                    got_d.push_back(rsp_data); got_l.push_back(rsp_last); got_e.push_back(rsp_err);
                    done = rsp_last;
                    have_hold = 1'b0;
                end else begin
                    have_hold = 1'b1;
                    hold = rsp_data;
                end
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (!done) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [6:0] a, input logic [31:0] d);
        check({tag, "_addr"}, 32'(wr_a_log[idx]), 32'(a));
        check({tag, "_data"}, wr_d_log[idx], d);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int          wb, rb, rc, sb, polls, bad, nacc;
        bit          w3;
        logic [31:0] n, d;
        logic [6:0]  a;
        logic [31:0] steps_list [6];

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 7'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_scratch[i] = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_flags", {30'd0, rsp_last, rsp_err}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_strobes", {30'd0, m_read, m_write}, 32'd0);
        check("rst_m_addr", 32'(m_address), 32'd0);
        check("rst_m_wdata", m_writedata, 32'd0);

        // HALT: clear steps then enable manual stepping, no response
        wb = wr_a_log.size(); rb = rd_log.size(); rc = rsp_cnt;
        send("halt", OP_HALT, 7'd0, 32'd0);
        wait_idle("halt_done");
        repeat (3) @(negedge clk);
        check("halt_nwr", 32'(wr_a_log.size() - wb), 32'd2);
        expect_wr("halt_wr0", wb, 7'h0C, 32'd0);
        expect_wr("halt_wr1", wb + 1, 7'h08, 32'd1);
        check("halt_nrd", 32'(rd_log.size() - rb), 32'd0);
        check("halt_norsp", 32'(rsp_cnt - rc), 32'd0);
        check("halt_step_en", s_step_en, 32'd1);
        check("halt_steps", s_steps, 32'd0);

        // RUN
        wb = wr_a_log.size(); rc = rsp_cnt;
        send("run", OP_RUN, 7'd0, 32'd0);
        wait_idle("run_done");
        repeat (3) @(negedge clk);
        check("run_nwr", 32'(wr_a_log.size() - wb), 32'd1);
        expect_wr("run_wr0", wb, 7'h08, 32'd0);
        check("run_norsp", 32'(rsp_cnt - rc), 32'd0);

        // STEP: slave drains one per cycle, polls land every second cycle -> (N+2)/2 polls
        steps_list = '{32'd5, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        for (int k = 2; k < 6; k++) steps_list[k] = 32'($urandom_range(1, 60));
        foreach (steps_list[k]) begin
            n = steps_list[k];
            polls = int'((n + 32'd2) / 32'd2);
            wb = wr_a_log.size(); rb = rd_log.size();
            send("step", OP_STEP, 7'd0, n);
            collect(1'b0);
            check("step_nwr", 32'(wr_a_log.size() - wb), 32'd2);
            expect_wr("step_wr0", wb, 7'h0C, n);
            expect_wr("step_wr1", wb + 1, 7'h08, 32'd1);
            check("step_nrd", 32'(rd_log.size() - rb), 32'(polls));
            bad = 0;
            for (int i = rb; i < rd_log.size(); i++) if (rd_log[i] != 7'h0C) bad++;
            check("step_rd_addr", 32'(bad), 32'd0);
            check("step_nrsp", 32'(got_d.size()), 32'd1);
            check("step_data", got_d[0], 32'(polls));
            check("step_flags", {30'd0, got_l[0], got_e[0]}, 32'b10);
        end

        // STEP that never drains: exactly POLL_TIMEOUT polls then error with last value
        freeze = 1'b1;
        rb = rd_log.size();
        send("step_to", OP_STEP, 7'd0, 32'd100);
        collect(1'b0);
        freeze = 1'b0;
        check("stepto_nrd", 32'(rd_log.size() - rb), 32'd4096);
        check("stepto_nrsp", 32'(got_d.size()), 32'd1);
        check("stepto_data", got_d[0], 32'd100);
        check("stepto_flags", {30'd0, got_l[0], got_e[0]}, 32'b11);

        // SNAPSHOT with a steady consumer, then with a consumer toggling every cycle
        for (int t = 0; t < 2; t++) begin
            rb = rd_log.size();
            send("snap", OP_SNAPSHOT, 7'd0, 32'd0);
            collect(t[0]);
            check("snap_nrsp", 32'(got_d.size()), 32'd7);
            check("snap_nrd", 32'(rd_log.size() - rb), 32'd7);
            for (int i = 0; i < 7 && i < got_d.size(); i++) begin
                check("snap_data", got_d[i], EXP_SNAP[i]);
                check("snap_last", 32'(got_l[i]), (i == 6) ? 32'd1 : 32'd0);
                check("snap_err", 32'(got_e[i]), 32'd0);
                check("snap_addr", 32'(rd_log[rb + i]), 32'(EXP_SNAP_A[i]));
            end
        end

        // WRITE then READ of scratch
        send("wr", OP_WRITE, 7'h40, 32'hCAFE_BABE);
        ref_scratch[0] = 32'hCAFE_BABE;
        send("rd", OP_READ, 7'h40, 32'd0);
        collect(1'b0);
        check("rd_nrsp", 32'(got_d.size()), 32'd1);
        check("rd_data", got_d[0], 32'hCAFE_BABE);
        check("rd_flags", {30'd0, got_l[0], got_e[0]}, 32'b10);

        // Random scratch traffic with unaligned byte addresses against an array model
        for (int k = 0; k < 12; k++) begin
            a = 7'h40 | 7'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                ref_scratch[a[5:2]] = d;
                wb = wr_a_log.size();
                send("rwr", OP_WRITE, a, d);
                wait_idle("rwr_done");
                expect_wr("rwr", wb, a & 7'h7C, d);
            end else begin
                send("rrd", OP_READ, a, 32'd0);
                collect(1'b0);
                check("rrd_data", got_d[0], ref_scratch[a[5:2]]);
            end
        end

        // Illegal opcodes: tagged error response, no bus access
        for (int op = 6; op < 8; op++) begin
            sb = strobe_cnt;
            send("ill", 3'(op), 7'd0, 32'd0);
            collect(1'b0);
            check("ill_data", got_d[0], 32'hDEAD_0000 + 32'(op));
            check("ill_flags", {30'd0, got_l[0], got_e[0]}, 32'b11);
            check("ill_nostrobe", 32'(strobe_cnt - sb), 32'd0);
        end

        // Reset while the third snapshot word is waiting
        send("snap_rst", OP_SNAPSHOT, 7'd0, 32'd0);
        nacc = 0; w3 = 1'b0;
        for (int c = 0; c < 200 && !w3; c++) begin
            @(negedge clk);
            rsp_ready = (nacc < 2);
            if (rsp_valid) begin
                if (rsp_ready) nacc++;
                else w3 = 1'b1;
            end
        end
        check("rst_w3_seen", 32'(w3), 32'd1);
        check("rst_w3_data", rsp_data, 32'h13);
        reset = 1'b1;
        sb = strobe_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_nostrobe", 32'(strobe_cnt - sb), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 16; i++) ref_scratch[i] = 32'd0;
        send("rd_after", OP_READ, 7'h44, 32'd0);
        collect(1'b0);
        check("rd_after_data", got_d[0], ref_scratch[1]);
        check("rd_after_flags", {30'd0, got_l[0], got_e[0]}, 32'b10);

        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
